conv_pool_rx: RTL and testbench

- Receiver and reducer for the Conv result stream.
- Accepts the start strobe and the raster-ordered 16-bit conv words exactly as Conv emits them (out_st/dout).
- Performs non-overlapping POOLxPOOL max-pooling on the fly, with no frame buffer.
- Emits each pooled value with a valid/index tag, then a done pulse.
- Replaces the bench-side capture array and MaxPool hookup; feeds downstream layers.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_pool_rx_if.sv | 24 ++
 rtl/max_cmp.sv | 12 +
 rtl/conv_pool_rx.sv | 124 ++++++++++++
 tb/tb_conv_pool_rx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the Conv result stream and its pooling receiver.
package conv_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned IMG_W       = 6;
  localparam int unsigned POOL        = 3;
  localparam int unsigned OUT_W       = IMG_W / POOL;
  localparam int unsigned N_OUT       = OUT_W * OUT_W;
  localparam int unsigned FRAME_WORDS = IMG_W * IMG_W;

  // Counter/index widths never collapse to zero bits for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDX_W = clog2_min1(N_OUT);
  localparam int unsigned PC_W  = clog2_min1(POOL);
  localparam int unsigned PJ_W  = clog2_min1(OUT_W);

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/conv_pool_rx_if.sv
// Conv word stream in, pooled result stream out.
interface conv_pool_rx_if
  import conv_pkg::*;
();

  logic             in_st;
  word_t            din;
  word_t            pool_dout;
  logic             pool_valid;
  logic [IDX_W-1:0] pool_idx;
  logic             done;
  logic             busy;

  modport master (
    output in_st, din,
    input  pool_dout, pool_valid, pool_idx, done, busy
  );

  modport slave (
    input  in_st, din,
    output pool_dout, pool_valid, pool_idx, done, busy
  );

endinterface

// File: rtl/max_cmp.sv
// Unsigned two-input maximum, purely combinational.
module max_cmp #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max_c
);

  assign max_c = (a >= b) ? a : b;

endmodule

// File: rtl/conv_pool_rx.sv
// Receives a raster-ordered Conv frame and emits non-overlapping POOLxPOOL maxima
// on the fly, keeping only one running maximum per pooled column.
module conv_pool_rx
  import conv_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  conv_pool_rx_if.slave   bus
);

  state_e            state;
  logic [PC_W-1:0]   pc;   // col % POOL
  logic [PJ_W-1:0]   pj;   // col / POOL
  logic [PC_W-1:0]   pr;   // row % POOL
  logic [PJ_W-1:0]   pi;   // row / POOL
  word_t             acc [OUT_W];
  word_t             acc_sel;
  word_t             win_max;
  logic              win_first;
  logic              win_last;
  logic              frame_last;

  assign acc_sel    = acc[pj];
  assign win_first  = (pr == '0) && (pc == '0);
  assign win_last   = (pr == PC_W'(POOL - 1)) && (pc == PC_W'(POOL - 1));
  assign frame_last = win_last && (pi == PJ_W'(OUT_W - 1)) && (pj == PJ_W'(OUT_W - 1));

  // Single comparator serves both the accumulator update and the emitted result.
  max_cmp #(.W(DATA_W)) u_max (
    .a     (acc_sel),
    .b     (bus.din),
    .max_c (win_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= '0;
      pj             <= '0;
      pr             <= '0;
      pi             <= '0;
      for (int j = 0; j < OUT_W; j++) acc[j] <= '0;
      bus.pool_dout  <= '0;
      bus.pool_valid <= 1'b0;
      bus.pool_idx   <= '0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.pool_valid <= 1'b0;
      bus.done       <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_st) begin
            state    <= RECV;
            bus.busy <= 1'b1;
            pc       <= '0;
            pj       <= '0;
            pr       <= '0;
            pi       <= '0;
          end
        end

        RECV: begin
          if (bus.in_st) begin
            // Restart: the strobe cycle's word is not part of the new frame.
            pc <= '0;
            pj <= '0;
            pr <= '0;
            pi <= '0;
          end else begin
            acc[pj] <= win_first ? bus.din : win_max;

            if (win_last) begin
              bus.pool_dout  <= win_max;
              bus.pool_valid <= 1'b1;
              bus.pool_idx   <= IDX_W'(32'(pi) * OUT_W + 32'(pj));
            end

            // Raster walk split into window-local and window-index parts.
            if (pc == PC_W'(POOL - 1)) begin
              pc <= '0;
              if (pj == PJ_W'(OUT_W - 1)) begin
                pj <= '0;
                if (pr == PC_W'(POOL - 1)) begin
                  pr <= '0;
                  pi <= (pi == PJ_W'(OUT_W - 1)) ? '0 : pi + PJ_W'(1);
                end else begin
                  pr <= pr + PC_W'(1);
                end
              end else begin
                pj <= pj + PJ_W'(1);
              end
            end else begin
              pc <= pc + PC_W'(1);
            end

            if (frame_last) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end
          end
        end

        DONE: begin
          if (bus.in_st) begin
            state    <= RECV;
            bus.busy <= 1'b1;
            pc       <= '0;
            pj       <= '0;
            pr       <= '0;
            pi       <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_rx.sv
// Directed and randomized frames for conv_pool_rx, checked against a window-max model.
module tb_conv_pool_rx;
  import conv_pkg::*;

  localparam int unsigned FW = FRAME_WORDS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_pool_rx_if bus ();

  conv_pool_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_idx[$];
  int q_dout[$];
  int q_cyc[$];
  int q_done[$];
  int busy_cnt = 0;

  // Observe outputs away from the active edge.
  always @(negedge clk) begin
    if (bus.pool_valid === 1'b1) begin
      q_idx.push_back(int'(bus.pool_idx));
      q_dout.push_back(int'(bus.pool_dout));
      q_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) q_done.push_back(cyc);
    if (bus.busy === 1'b1) busy_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  word_t fa [FW];
  word_t fb [FW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: maximum of pooling window (r,c) taken directly over the frame.
  function automatic int win_ref(input word_t f [FW], input int r, input int c);
    int m = 0;
    for (int a = 0; a < POOL; a++)
      for (int b = 0; b < POOL; b++) begin
        int w = int'(f[(r * POOL + a) * IMG_W + c * POOL + b]);
        if (w > m) m = w;
      end
    return m;
  endfunction

  function automatic int win_end(input int r, input int c);
    return (r * POOL + POOL - 1) * IMG_W + c * POOL + POOL - 1;
  endfunction

  task automatic clear_mon();
    q_idx.delete();
    q_dout.delete();
    q_cyc.delete();
    q_done.delete();
    busy_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_st = 1'b0;
      bus.din   = word_t'($urandom);
    end
  endtask

  // Strobe, then the first n words of f on consecutive cycles; t0 = strobe edge.
  task automatic drive_frame(input word_t f [FW], input int n, output int t0);
    @(negedge clk);
    bus.in_st = 1'b1;
    bus.din   = word_t'($urandom);
    t0 = cyc + 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_st = 1'b0;
      bus.din   = f[k];
    end
  endtask

  task automatic check_emits(input string tag, input word_t f [FW], input int t0,
                             input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int r = i / OUT_W;
      int c = i % OUT_W;
      chk($sformatf("%s_present%0d", tag, i), 64'(q_idx.size() > base + i), 64'd1);
      if (q_idx.size() > base + i) begin
        chk($sformatf("%s_idx%0d", tag, i), 64'(q_idx[base + i]), 64'(i));
        chk($sformatf("%s_dout%0d", tag, i), 64'(q_dout[base + i]), 64'(win_ref(f, r, c)));
        chk($sformatf("%s_cyc%0d", tag, i), 64'(q_cyc[base + i]), 64'(t0 + 1 + win_end(r, c)));
      end
    end
  endtask

  task automatic run_std(input string tag, input word_t f [FW]);
    int t0;
    clear_mon();
    drive_frame(f, FW, t0);
    idle(4);
    chk({tag, "_nout"}, 64'(q_idx.size()), 64'(N_OUT));
    check_emits(tag, f, t0, 0, N_OUT);
    chk({tag, "_ndone"}, 64'(q_done.size()), 64'd1);
    if (q_done.size() >= 1) chk({tag, "_donecyc"}, 64'(q_done[0]), 64'(t0 + FW));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(FW));
  endtask

  initial begin
    int t0;
    int t1;

    rst_n     = 1'b0;
    bus.in_st = 1'b0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout",  64'(bus.pool_dout),  64'd0);
    chk("rst_valid", 64'(bus.pool_valid), 64'd0);
    chk("rst_idx",   64'(bus.pool_idx),   64'd0);
    chk("rst_done",  64'(bus.done),       64'd0);
    chk("rst_busy",  64'(bus.busy),       64'd0);
    rst_n = 1'b1;
    idle(2);

    // Ramp: expected (14,17,32,35)
    for (int k = 0; k < FW; k++) fa[k] = word_t'(k);
    run_std("ramp", fa);
    if (q_dout.size() == N_OUT) chk("ramp_last_abs", 64'(q_dout[N_OUT - 1]), 64'd35);

    for (int k = 0; k < FW; k++) fa[k] = word_t'(FW - 1 - k);
    run_std("desc", fa);

    for (int k = 0; k < FW; k++) fa[k] = 16'h7FFF;
    fa[7]  = 16'h8000;
    fa[28] = 16'hFFFF;
    run_std("peak", fa);

    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < FW; k++)
        fa[k] = (n == 2) ? word_t'($urandom_range(0, 3)) : word_t'($urandom);
      run_std($sformatf("rand%0d", n), fa);
    end

    // Restart after word 20, then a frame of 5s.
    for (int k = 0; k < FW; k++) fa[k] = word_t'(k);
    for (int k = 0; k < FW; k++) fb[k] = 16'h0005;
    clear_mon();
    drive_frame(fa, 21, t0);
    drive_frame(fb, FW, t1);
    idle(4);
    chk("restart_nout", 64'(q_idx.size()), 64'(2 + N_OUT));
    check_emits("abort", fa, t0, 0, 2);
    check_emits("restart_new", fb, t1, 2, N_OUT);
    chk("restart_ndone", 64'(q_done.size()), 64'd1);
    if (q_done.size() >= 1) chk("restart_donecyc", 64'(q_done[0]), 64'(t1 + FW));

    // Reset pulse at word 10.
    clear_mon();
    drive_frame(fa, 10, t0);
    @(negedge clk);
    bus.din = fa[10];
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.din = fa[11];
    chk("midrst_dout",  64'(bus.pool_dout),  64'd0);
    chk("midrst_idx",   64'(bus.pool_idx),   64'd0);
    chk("midrst_valid", 64'(bus.pool_valid), 64'd0);
    chk("midrst_busy",  64'(bus.busy),       64'd0);
    for (int k = 12; k < FW; k++) begin
      @(negedge clk);
      bus.din = fa[k];
    end
    idle(4);
    chk("midrst_nout",  64'(q_idx.size()),  64'd0);
    chk("midrst_ndone", 64'(q_done.size()), 64'd0);
    run_std("post_rst", fa);

    // Back-to-back: second strobe lands in the done cycle.
    for (int k = 0; k < FW; k++) fa[k] = word_t'($urandom);
    for (int k = 0; k < FW; k++) fb[k] = 16'h0001;
    clear_mon();
    drive_frame(fa, FW, t0);
    drive_frame(fb, FW, t1);
    idle(4);
    chk("b2b_nout", 64'(q_idx.size()), 64'(2 * N_OUT));
    check_emits("b2b_a", fa, t0, 0, N_OUT);
    check_emits("b2b_b", fb, t1, N_OUT, N_OUT);
    chk("b2b_ndone", 64'(q_done.size()), 64'd2);
    if (q_done.size() >= 2) begin
      chk("b2b_done0", 64'(q_done[0]), 64'(t0 + FW));
      chk("b2b_gap", 64'(q_done[1] - q_done[0]), 64'(FW + 1));
    end
    chk("b2b_busy", 64'(busy_cnt), 64'(2 * FW));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
